// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the fetch-side run controller: HALT/NOP encodings and FSM states.
package cpu_run_ctrl_pkg;

    localparam logic [4:0]  HALT_OP  = 5'h1F;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStep  = 2'd2,
        StDrain = 2'd3
    } run_state_e;

    // A drain of one cycle still needs a one-bit counter.
    function automatic int unsigned drain_cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_drain_cnt.sv
// Loadable down-counter with zero flag; times the pipeline drain.
module cpu_run_drain_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Fetch-side run controller: host start/step/stop, HALT detection, pipeline drain, retire count.
// Define RUN_CTRL_BREAK_EN to add a PC breakpoint comparator (pc, brk_addr, brk_en, brk_hit).
import cpu_run_ctrl_pkg::*;

module cpu_run_ctrl #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic [15:0]      if_ir,
    input  logic             wb_valid,
    output logic             fetch_en,
    output logic             inject_nop,
    output logic             running,
    output logic             halted,
    output logic             done,
    output logic [CNT_W-1:0] retired
`ifdef RUN_CTRL_BREAK_EN
    ,
    input  logic [15:0]      pc,
    input  logic [15:0]      brk_addr,
    input  logic             brk_en,
    output logic             brk_hit
`endif
);

    localparam int unsigned   CW         = drain_cnt_width(DEPTH);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DEPTH - 1);

    run_state_e       state_q, state_d;
    logic             fetch_en_q, inject_nop_q, running_q, halted_q, done_q;
    logic [CNT_W-1:0] retired_q;
    logic             drain_zero, drain_load, accept, halt_fetch, brk_match, drain_exit;

    logic unused_ir;
    assign unused_ir = ^if_ir[10:0];

`ifdef RUN_CTRL_BREAK_EN
    logic brk_hit_q;
    assign brk_match = (state_q == StRun) && brk_en && (pc == brk_addr);
`else
    assign brk_match = 1'b0;
`endif

    assign halt_fetch = (if_ir[15:11] == HALT_OP);
    assign accept     = (state_q == StIdle) && (start || step);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end else if (step) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (halt_fetch || stop || brk_match) begin
                    state_d = StDrain;
                end
            end
            StStep:  state_d = StDrain;
            StDrain: begin
                if (drain_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign drain_load = (state_q != StDrain) && (state_d == StDrain);
    assign drain_exit = (state_q == StDrain) && (state_d == StIdle);

    cpu_run_drain_cnt #(
        .W (CW)
    ) u_drain_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (drain_load),
        .load_val (DRAIN_LOAD),
        .dec      (state_q == StDrain),
        .zero     (drain_zero)
    );

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            fetch_en_q   <= 1'b0;
            inject_nop_q <= 1'b1;
            running_q    <= 1'b0;
            halted_q     <= 1'b1;
            done_q       <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_en_q   <= (state_d == StRun) || (state_d == StStep);
            inject_nop_q <= !((state_d == StRun) || (state_d == StStep));
            running_q    <= (state_d == StRun) || (state_d == StStep);
            done_q       <= drain_exit;
            if (accept) begin
                halted_q <= 1'b0;
            end else if (drain_exit) begin
                halted_q <= 1'b1;
            end
            if ((state_q == StIdle) && start) begin
                retired_q <= '0;
            end else if (wb_valid) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

`ifdef RUN_CTRL_BREAK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            brk_hit_q <= 1'b0;
        end else if (accept) begin
            brk_hit_q <= 1'b0;
        end else if (brk_match) begin
            brk_hit_q <= 1'b1;
        end
    end

    assign brk_hit = brk_hit_q;
`endif

    // A breakpoint hit suppresses the fetch of the matching address in the same cycle.
    assign fetch_en   = fetch_en_q && !brk_match;
    assign inject_nop = inject_nop_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign done       = done_q;
    assign retired    = retired_q;

endmodule
